// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver on the system clock; `UART_RX_MAJORITY_EN selects 2-of-3 sampling around mid-bit.
// Outputs register one cycle after the stop decision; a byte completing while valid && !ready is dropped with overrun.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC = H + 1;
`else
  localparam int DEC = H;
`endif
  localparam logic [CW-1:0] DEC_CNT  = CW'(DEC);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t          state, state_nxt;
  logic            rx_meta, rxs;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            sample, at_dec, load, ferr;

`ifdef UART_RX_MAJORITY_EN
  // hist[0] holds rxs from one cycle back, hist[1] from two cycles back
  logic [1:0] hist;
  always_ff @(posedge clk) begin
    if (rst) hist <= 2'b11;
    else     hist <= {hist[0], rxs};
  end
  assign sample = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
`else
  assign sample = rxs;
`endif

  assign at_dec = (cnt == DEC_CNT);
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ferr      = 1'b0;
    case (state)
      IDLE:  if (!rxs) state_nxt = START;
      START: if (at_dec) state_nxt = sample ? IDLE : DATA;
      DATA:  if (at_dec && bit_idx == 3'd7) state_nxt = STOP;
      STOP: begin
        if (at_dec) begin
          if (sample) begin
            state_nxt = IDLE;
            load      = 1'b1;
          end else begin
            state_nxt = BRK;
            ferr      = 1'b1;
          end
        end
      end
      BRK:   if (rxs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      state   <= state_nxt;

      // cnt tracks cycles since the start edge, so IDLE preloads 1 for the first START cycle
      if (state == IDLE)         cnt <= CW'(1);
      else if (cnt == LAST_CNT)  cnt <= '0;
      else                       cnt <= cnt + CW'(1);

      if (state == START) bit_idx <= 3'd0;
      if (state == DATA && at_dec) begin
        shreg   <= {sample, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end

      frame_err <= ferr;
      overrun   <= 1'b0;
      if (load) begin
        if (!valid || ready) begin
          data  <= shreg;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: per-cycle stimulus tables, a frame-level model of expected outputs, literal spot checks.
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int N   = 1800;
`ifdef UART_RX_MAJORITY_EN
  localparam int D = CPB / 2 + 1;
  localparam logic [7:0] GLITCH_BYTE = 8'h00;
`else
  localparam int D = CPB / 2;
  localparam logic [7:0] GLITCH_BYTE = 8'h08;
`endif
  localparam int M = D - CPB / 2;

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] val;
  } lit_t;

  logic       clk, rst, rx, ready, valid, frame_err, overrun, busy;
  logic [7:0] data;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid), .ready(ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus tables, index k = value driven just after rising edge k
  logic       line [N];
  logic       rdy  [N];
  logic       rs   [N];
  // expected outputs, index j = value held after rising edge j
  logic       exp_valid [N];
  logic       exp_ferr  [N];
  logic       exp_ovr   [N];
  logic       exp_busy  [N];
  logic [7:0] exp_data  [N];
  int         ev_kind   [N];
  logic [7:0] ev_byte   [N];
  lit_t       lits[$];

  int total  = 0;
  int passed = 0;

  function automatic logic rst_edge(int j);
    if (j <= 0) return 1'b1;
    if (j - 1 >= N) return 1'b0;
    return rs[j-1];
  endfunction

  // synchronized line value seen by the receiver during cycle j
  function automatic logic s_at(int j);
    if (j < 2 || j - 2 >= N) return 1'b1;
    if (rst_edge(j) || rst_edge(j - 1)) return 1'b1;
    return line[j-2];
  endfunction

  function automatic logic decide(int t);
`ifdef UART_RX_MAJORITY_EN
    int ones;
    ones = int'(s_at(t - 2)) + int'(s_at(t - 1)) + int'(s_at(t));
    return (ones >= 2);
`else
    return s_at(t);
`endif
  endfunction

  task automatic put_frame(int p, logic [7:0] b, logic stop);
    logic v;
    for (int n = 0; n < 10; n++) begin
      if (n == 0)      v = 1'b0;
      else if (n == 9) v = stop;
      else             v = b[n-1];
      for (int k = 0; k < CPB; k++) line[p + n*CPB + k] = v;
    end
  endtask

  task automatic add_lit(int c, int s, logic [7:0] v);
    lit_t l;
    l.cyc = c; l.sel = s; l.val = v;
    lits.push_back(l);
  endtask

  task automatic run_model();
    int j, c0, e_ev, e_idle, r, kind, stop_at;
    logic [7:0] byt, d;
    logic v, pr, f, o;
    for (int i = 0; i < N; i++) begin
      ev_kind[i] = 0; ev_byte[i] = 8'h00; exp_busy[i] = 1'b0;
    end
    j = 0;
    while (j < N) begin
      if (s_at(j)) begin
        j++;
      end else begin
        c0 = j; kind = 0; byt = 8'h00;
        if (decide(c0 + D)) begin
          e_ev = c0 + D + 1;
          e_idle = e_ev;
        end else begin
          for (int n = 1; n <= 8; n++) byt[n-1] = decide(c0 + n*CPB + D);
          e_ev = c0 + 9*CPB + D + 1;
          e_idle = e_ev;
          if (decide(c0 + 9*CPB + D)) kind = 1;
          else begin
            kind = 2;
            while (e_idle < N && !s_at(e_idle)) e_idle++;
            e_idle++;
          end
        end
        r = N + 100;
        for (int k = c0 + 1; k <= e_idle && k < N; k++)
          if (rst_edge(k) && r > k) r = k;
        if (r <= e_ev) kind = 0;
        stop_at = (r < e_idle) ? r : e_idle;
        if (kind != 0 && e_ev < N) begin
          ev_kind[e_ev] = kind;
          ev_byte[e_ev] = byt;
        end
        for (int k = c0 + 1; k < stop_at && k < N; k++) exp_busy[k] = 1'b1;
        j = stop_at;
      end
    end
    v = 1'b0; d = 8'h00;
    for (int i = 0; i < N; i++) begin
      f = 1'b0; o = 1'b0;
      if (rst_edge(i)) begin
        v = 1'b0; d = 8'h00;
      end else begin
        pr = (i >= 1) ? rdy[i-1] : 1'b1;
        if (ev_kind[i] == 1) begin
          if (!v || pr) begin d = ev_byte[i]; v = 1'b1; end
          else o = 1'b1;
        end else begin
          if (v && pr) v = 1'b0;
          if (ev_kind[i] == 2) f = 1'b1;
        end
      end
      exp_valid[i] = v; exp_data[i] = d; exp_ferr[i] = f; exp_ovr[i] = o;
    end
  endtask

  task automatic build();
    for (int k = 0; k < N; k++) begin
      line[k] = 1'b1; rdy[k] = 1'b1; rs[k] = 1'b0;
    end
    for (int k = 0; k < 4; k++) rs[k] = 1'b1;
    put_frame(20, 8'h55, 1'b1);
    for (int k = 220; k < 223; k++) line[k] = 1'b0;
    put_frame(260, 8'hA5, 1'b0);
    for (int k = 420; k < 460; k++) line[k] = 1'b0;
    put_frame(480, 8'h3C, 1'b1);
    for (int k = 680; k < 1120; k++) rdy[k] = 1'b0;
    rdy[1100] = 1'b1;
    put_frame(700, 8'h11, 1'b1);
    put_frame(860, 8'h22, 1'b1);
    put_frame(1140, 8'hF0, 1'b1);
    rs[1228] = 1'b1;
    put_frame(1320, 8'h81, 1'b1);
    put_frame(1520, 8'h00, 1'b1);
    line[1592] = 1'b1;

    for (int s = 0; s < 5; s++) add_lit(3, s, 8'h00);
    add_lit(174 + M, 0, 8'h00);  add_lit(175 + M, 0, 8'h01);
    add_lit(175 + M, 1, 8'h55);  add_lit(176 + M, 0, 8'h00);
    add_lit(225, 4, 8'h01);      add_lit(232, 4, 8'h00);
    add_lit(415 + M, 2, 8'h01);  add_lit(415 + M, 0, 8'h00);
    add_lit(416 + M, 2, 8'h00);
    add_lit(462, 4, 8'h01);      add_lit(463, 4, 8'h00);
    add_lit(635 + M, 0, 8'h01);  add_lit(635 + M, 1, 8'h3C);
    add_lit(855 + M, 1, 8'h11);  add_lit(1015 + M, 3, 8'h01);
    add_lit(1015 + M, 1, 8'h11); add_lit(1100, 0, 8'h01);
    add_lit(1101, 0, 8'h00);
    add_lit(1228, 4, 8'h01);     add_lit(1229, 4, 8'h00);
    add_lit(1229, 0, 8'h00);     add_lit(1229, 1, 8'h00);
    add_lit(1475 + M, 0, 8'h01); add_lit(1475 + M, 1, 8'h81);
    add_lit(1675 + M, 0, 8'h01); add_lit(1675 + M, 1, GLITCH_BYTE);
  endtask

  initial begin : drive
    rst = 1'b1; rx = 1'b1; ready = 1'b1;
    build();
    run_model();
    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      #1;
      rx = line[k]; ready = rdy[k]; rst = rs[k];
    end
  end

  initial begin : compare
    logic [11:0] got, want;
    logic [7:0]  g;
    string       nm;
    for (int j = 0; j < N; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j >= 1) begin
        got  = {valid, frame_err, overrun, busy, data};
        want = {exp_valid[j], exp_ferr[j], exp_ovr[j], exp_busy[j], exp_data[j]};
        total++;
        if (got === want) passed++;
        else $display("FAIL model cyc=%0d v/fe/ov/busy/data got %b/%b/%b/%b/%02h want %b/%b/%b/%b/%02h",
                      j, got[11], got[10], got[9], got[8], got[7:0],
                      want[11], want[10], want[9], want[8], want[7:0]);
      end
      foreach (lits[i]) begin
        if (lits[i].cyc == j) begin
          case (lits[i].sel)
            0:       begin g = {7'd0, valid};     nm = "valid";     end
            1:       begin g = data;              nm = "data";      end
            2:       begin g = {7'd0, frame_err}; nm = "frame_err"; end
            3:       begin g = {7'd0, overrun};   nm = "overrun";   end
            default: begin g = {7'd0, busy};      nm = "busy";      end
          endcase
          total++;
          if (g === lits[i].val) passed++;
          else $display("FAIL lit_%s cyc=%0d got %02h want %02h", nm, j, g, lits[i].val);
        end
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
